time_set_ctrl: RTL
==================

Name: time_set_ctrl

Overview:
Button-driven controller that sequences time-setting and alarm configuration for the digital clock. It takes debounced single-cycle key pulses and walks a mode FSM through hour/min/sec time editing and alarm hour/min editing. It drives the BCD set-time digits plus a one-cycle commit strobe into the timekeeping core, and drives the alarm digits and alarm enable. It also produces a field-select code and blink signal for the display controller.

Parameters:
TIMEOUT_CYC, 500000000, idle cycles in any edit state before auto-return to RUN (10 s at 50 MHz); minimum 2
BLINK_HALF, 25000000, cycles per blink half-period; minimum 1
CNT_W, 32, width of the timeout and blink counters; must hold TIMEOUT_CYC-1

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
key_mode  in  1  one-cycle pulse: advance edit field
key_inc  in  1  one-cycle pulse: increment current field
key_alarm  in  1  one-cycle pulse: toggle alarm enable
cur_hour_shi, cur_hour_ge, cur_min_shi, cur_min_ge, cur_sec_shi, cur_sec_ge  in  4 each  live BCD time from the timekeeping core
set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge  out  4 each  BCD time to load
set_time_finish  out  1  one-cycle commit strobe for the set_* values
clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge  out  4 each  BCD alarm time
clock_en  out  1  alarm enable
edit_field  out  3  current FSM state code
blink  out  1  blink phase for the field being edited

Behaviour:
- All outputs are registered. Each reacts in the cycle after the key pulse that causes it.
- Reset values: state RUN (edit_field=0); set_* = 12:00:00; clock_* = 07:00; clock_en=0; set_time_finish=0; blink=0; counters=0.
- Reset has priority over all keys. Asserting rst mid-edit discards edits, restores the reset values above and issues no strobe.
- FSM states and codes: RUN=0, T_HOUR=1, T_MIN=2, T_SEC=3, A_HOUR=4, A_MIN=5. Codes 6 and 7 are illegal and go to RUN on the next cycle.
- key_mode advances the state: RUN→T_HOUR→T_MIN→T_SEC→A_HOUR→A_MIN→RUN.
- On the RUN→T_HOUR transition, set_* load cur_* in the same edge.
- On the T_SEC→A_HOUR transition, set_time_finish=1 for exactly one cycle. set_* are stable on that cycle and stay stable afterwards.
- key_inc is ignored in RUN. In an edit state it increments the selected field in BCD:
  - ge+1; when ge is 9, ge becomes 0 and shi is incremented.
  - Minutes and seconds wrap 59→00.
  - Hours wrap 23→00; the 09→10 and 19→20 carries are exercised.
- key_inc in A_HOUR or A_MIN edits the clock_* registers with the same BCD rules.
- All set_* and clock_* registers always hold valid BCD within range.
- If key_mode and key_inc arrive together, key_mode wins and key_inc is dropped.
- key_alarm toggles clock_en in any state. It is independent of the other keys, so it also takes effect when it coincides with key_mode or key_inc.
- Timeout counter:
  - Cleared in RUN and on any key pulse; increments every cycle in edit states.
  - When it equals TIMEOUT_CYC-1, the state goes to RUN on the next edge.
  - No set_time_finish strobe is issued on timeout. Uncommitted set_* values are kept, but the next RUN→T_HOUR entry overwrites them from cur_*.
  - A key pulse arriving on the terminal-count cycle wins: the counter clears and the state is processed normally.
- Blink counter:
  - blink=0 and counter=0 in RUN, on any key pulse and on any state change.
  - In edit states, blink toggles each time the counter reaches BLINK_HALF-1, then the counter wraps to 0.

Test Plan:
- Reset, then hold cur_*=08:15:42 and pulse key_mode → edit_field=1, set_*=08:15:42 next cycle, set_time_finish stays 0.
- In T_HOUR starting from 08, 16 key_inc pulses → set_hour reaches 23 after 15, 00 after 16 (BCD carries at 09→10 and 19→20 observed). key_mode ×3 → set_time_finish high exactly one cycle on entry to A_HOUR, set_* = 00:15:42.
- In T_MIN at 59, key_inc → 00 with set_hour unchanged. In A_MIN at 59, key_inc → clock_min=00. key_mode+key_inc on the same cycle → state advances, value unchanged.
- With TIMEOUT_CYC=8 and BLINK_HALF=2: enter T_SEC and idle → blink toggles every 2 cycles, state returns to RUN 8 cycles after the last key, no strobe. A key on cycle 7 postpones the return by 8 more cycles.
- key_alarm in RUN → clock_en=1; key_alarm coincident with key_inc in A_HOUR → clock_en toggles and clock_hour increments.
- rst asserted in T_MIN after edits → next cycle edit_field=0, set_*=12:00:00, clock_*=07:00, clock_en=0, no strobe. Force illegal state code 6 → RUN next cycle.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Key-driven time/alarm setting controller: walks RUN -> time edit -> alarm edit,
// edits BCD fields, issues the time commit strobe and drives display field/blink.
module time_set_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 500000000,
    parameter int unsigned BLINK_HALF  = 25000000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_mode,
    input  logic       i_key_inc,
    input  logic       i_key_alarm,
    input  logic [3:0] i_cur_hour_shi,
    input  logic [3:0] i_cur_hour_ge,
    input  logic [3:0] i_cur_min_shi,
    input  logic [3:0] i_cur_min_ge,
    input  logic [3:0] i_cur_sec_shi,
    input  logic [3:0] i_cur_sec_ge,
    output logic [3:0] o_set_hour_shi,
    output logic [3:0] o_set_hour_ge,
    output logic [3:0] o_set_min_shi,
    output logic [3:0] o_set_min_ge,
    output logic [3:0] o_set_sec_shi,
    output logic [3:0] o_set_sec_ge,
    output logic       o_set_time_finish,
    output logic [3:0] o_clock_hour_shi,
    output logic [3:0] o_clock_hour_ge,
    output logic [3:0] o_clock_min_shi,
    output logic [3:0] o_clock_min_ge,
    output logic       o_clock_en,
    output logic [2:0] o_edit_field,
    output logic       o_blink
);

    localparam logic [2:0] StRun   = 3'd0;
    localparam logic [2:0] StTHour = 3'd1;
    localparam logic [2:0] StTMin  = 3'd2;
    localparam logic [2:0] StTSec  = 3'd3;
    localparam logic [2:0] StAHour = 3'd4;
    localparam logic [2:0] StAMin  = 3'd5;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] BL_LAST = CNT_W'(BLINK_HALF - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [CNT_W-1:0] r_to_cnt;
    logic [CNT_W-1:0] r_bl_cnt;
    logic             r_blink;
    logic             r_finish;
    logic             r_clock_en;
    logic [7:0]       r_set_hour;
    logic [7:0]       r_set_min;
    logic [7:0]       r_set_sec;
    logic [7:0]       r_clock_hour;
    logic [7:0]       r_clock_min;

    logic w_any_key;
    logic w_edit;
    logic w_timeout;
    logic w_inc_ok;
    logic w_load_set;
    logic w_commit;
    logic w_inc_th;
    logic w_inc_tm;
    logic w_inc_ts;
    logic w_inc_ah;
    logic w_inc_am;
    logic w_bl_clr;

    // {shi, ge} BCD increment; anything at or past the limit wraps to 00
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] max_shi,
                                           input logic [3:0] max_ge);
        if ((v[7:4] > max_shi) || ((v[7:4] == max_shi) && (v[3:0] >= max_ge))) begin
            return 8'h00;
        end else if (v[3:0] >= 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    assign w_any_key = i_key_mode | i_key_inc | i_key_alarm;
    assign w_edit    = (r_state != StRun) && (r_state <= StAMin);
    assign w_timeout = w_edit && (r_to_cnt == TO_LAST) && !w_any_key;
    assign w_inc_ok  = i_key_inc && !i_key_mode;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!w_edit) begin
            // Illegal codes fall back to RUN even if key_mode is present
            w_state_next = ((r_state == StRun) && i_key_mode) ? StTHour : StRun;
        end else if (i_key_mode) begin
            w_state_next = (r_state == StAMin) ? StRun : r_state + 3'd1;
        end else if (w_timeout) begin
            w_state_next = StRun;
        end
    end

    always_comb begin
        w_load_set = 1'b0;
        w_commit   = 1'b0;
        w_inc_th   = 1'b0;
        w_inc_tm   = 1'b0;
        w_inc_ts   = 1'b0;
        w_inc_ah   = 1'b0;
        w_inc_am   = 1'b0;
        case (r_state)
            StRun:   w_load_set = i_key_mode;
            StTHour: w_inc_th   = w_inc_ok;
            StTMin:  w_inc_tm   = w_inc_ok;
            StTSec: begin
                w_inc_ts = w_inc_ok;
                w_commit = i_key_mode;
            end
            StAHour: w_inc_ah   = w_inc_ok;
            StAMin:  w_inc_am   = w_inc_ok;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_set_hour <= 8'h12;
            r_set_min  <= 8'h00;
            r_set_sec  <= 8'h00;
            r_finish   <= 1'b0;
        end else begin
            r_finish <= w_commit;
            if (w_load_set) begin
                r_set_hour <= {i_cur_hour_shi, i_cur_hour_ge};
                r_set_min  <= {i_cur_min_shi, i_cur_min_ge};
                r_set_sec  <= {i_cur_sec_shi, i_cur_sec_ge};
            end else begin
                if (w_inc_th) r_set_hour <= bcd_inc(r_set_hour, 4'd2, 4'd3);
                if (w_inc_tm) r_set_min  <= bcd_inc(r_set_min, 4'd5, 4'd9);
                if (w_inc_ts) r_set_sec  <= bcd_inc(r_set_sec, 4'd5, 4'd9);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clock_hour <= 8'h07;
            r_clock_min  <= 8'h00;
            r_clock_en   <= 1'b0;
        end else begin
            if (i_key_alarm) r_clock_en <= ~r_clock_en;
            if (w_inc_ah) r_clock_hour <= bcd_inc(r_clock_hour, 4'd2, 4'd3);
            if (w_inc_am) r_clock_min  <= bcd_inc(r_clock_min, 4'd5, 4'd9);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !w_edit || w_any_key || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + CNT_W'(1);
        end
    end

    assign w_bl_clr = !w_edit || w_any_key || (w_state_next != r_state);

    always_ff @(posedge i_clk) begin
        if (i_rst || w_bl_clr) begin
            r_bl_cnt <= '0;
            r_blink  <= 1'b0;
        end else if (r_bl_cnt == BL_LAST) begin
            r_bl_cnt <= '0;
            r_blink  <= ~r_blink;
        end else begin
            r_bl_cnt <= r_bl_cnt + CNT_W'(1);
        end
    end

    assign o_set_hour_shi    = r_set_hour[7:4];
    assign o_set_hour_ge     = r_set_hour[3:0];
    assign o_set_min_shi     = r_set_min[7:4];
    assign o_set_min_ge      = r_set_min[3:0];
    assign o_set_sec_shi     = r_set_sec[7:4];
    assign o_set_sec_ge      = r_set_sec[3:0];
    assign o_set_time_finish = r_finish;
    assign o_clock_hour_shi  = r_clock_hour[7:4];
    assign o_clock_hour_ge   = r_clock_hour[3:0];
    assign o_clock_min_shi   = r_clock_min[7:4];
    assign o_clock_min_ge    = r_clock_min[3:0];
    assign o_clock_en        = r_clock_en;
    assign o_edit_field      = r_state;
    assign o_blink           = r_blink;

endmodule
